// File: rtl/life_engine_if.sv
// Edit/step/read bundle between the front end and the life_engine core.
interface life_engine_if #(
    parameter int XW   = 5,
    parameter int YW   = 5,
    parameter int POPW = 11
);
    logic            start;
    logic            clr;
    logic            wr_en;
    logic [XW-1:0]   wr_x;
    logic [YW-1:0]   wr_y;
    logic            wr_data;
    logic [XW-1:0]   rd_x;
    logic [YW-1:0]   rd_y;
    logic            rd_cell;
    logic            busy;
    logic            done;
    logic [15:0]     gen;
    logic [POPW-1:0] pop;

    modport master (
        output start, clr, wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        input  rd_cell, busy, done, gen, pop
    );

    modport slave (
        input  start, clr, wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        output rd_cell, busy, done, gen, pop
    );
endinterface

// File: rtl/life_engine.sv
// Cellular-automaton core: one grid row is evaluated per cycle into a
// shadow buffer, and the whole buffer is committed after the last row.
//
// state | meaning
// IDLE  | accept clear / cell edits / step request
// CALC  | evaluate row `row_q` into nxt_q, accumulate population
module life_engine #(
    parameter int       W      = 32,
    parameter int       H      = 24,
    parameter int       WRAP   = 1,
    parameter logic [8:0] RULE_B = 9'b000001000,
    parameter logic [8:0] RULE_S = 9'b000001100,
    parameter int       XW     = 5,
    parameter int       YW     = 5,
    parameter int       POPW   = 11
) (
    input  logic         clk,
    input  logic         rst,
    life_engine_if.slave bus
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t              state_q;
    logic [H-1:0][W-1:0] cur_q;
    logic [H-1:0][W-1:0] nxt_q;
    logic [YW-1:0]       row_q;
    logic [POPW-1:0]     acc_q;
    logic [POPW-1:0]     pop_q;
    logic [15:0]         gen_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_q;

    logic [W-1:0]        row_up;
    logic [W-1:0]        row_mid;
    logic [W-1:0]        row_dn;
    logic [W-1:0]        new_row;
    logic [POPW-1:0]     row_pop;
    logic                wr_ok;
    logic                rd_ok;
    logic                last_row;

    assign wr_ok    = (32'(bus.wr_x) < W) && (32'(bus.wr_y) < H);
    assign rd_ok    = (32'(bus.rd_x) < W) && (32'(bus.rd_y) < H);
    assign last_row = (row_q == YW'(H - 1));

    // Select the three source rows around row_q; edges wrap or read as dead.
    always_comb begin
        row_mid = cur_q[row_q];
        if (row_q == '0) begin
            row_up = (WRAP != 0) ? cur_q[H-1] : '0;
        end else begin
            row_up = cur_q[row_q - 1'b1];
        end
        if (last_row) begin
            row_dn = (WRAP != 0) ? cur_q[0] : '0;
        end else begin
            row_dn = cur_q[row_q + 1'b1];
        end
    end

    // Per-column neighbour count and rule lookup; column neighbours are fixed
    // at elaboration so the horizontal wrap costs no logic.
    for (genvar x = 0; x < W; x++) begin : g_cell
        localparam int   XL = (x == 0) ? W - 1 : x - 1;
        localparam int   XR = (x == W - 1) ? 0 : x + 1;
        localparam logic EL = (WRAP != 0) || (x != 0);
        localparam logic ER = (WRAP != 0) || (x != W - 1);
        logic [3:0] nbr;

        assign nbr = 4'(row_up[x]) + 4'(row_dn[x])
                   + 4'(EL & row_up[XL]) + 4'(EL & row_mid[XL]) + 4'(EL & row_dn[XL])
                   + 4'(ER & row_up[XR]) + 4'(ER & row_mid[XR]) + 4'(ER & row_dn[XR]);
        assign new_row[x] = row_mid[x] ? RULE_S[nbr] : RULE_B[nbr];
    end

    // Live-cell count of the row being produced this cycle.
    always_comb begin
        row_pop = '0;
        for (int i = 0; i < W; i++) begin
            row_pop = row_pop + POPW'(new_row[i]);
        end
    end

    // Control FSM with grid storage and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            nxt_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            pop_q   <= '0;
            gen_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clr) begin
                        cur_q <= '0;
                        pop_q <= '0;
                    end else begin
                        if (bus.wr_en && wr_ok) begin
                            cur_q[bus.wr_y][bus.wr_x] <= bus.wr_data;
                        end
                        if (bus.start) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            row_q   <= '0;
                            acc_q   <= '0;
                        end
                    end
                end
                CALC: begin
                    nxt_q[row_q] <= new_row;
                    acc_q        <= acc_q + row_pop;
                    row_q        <= row_q + 1'b1;
                    if (last_row) begin
                        // The final row has not landed in nxt_q yet, so it is
                        // patched into the committed grid directly.
                        cur_q        <= nxt_q;
                        cur_q[row_q] <= new_row;
                        pop_q        <= acc_q + row_pop;
                        gen_q        <= gen_q + 16'd1;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Registered read port for the renderer; shows the committed grid only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_ok ? cur_q[bus.rd_y][bus.rd_x] : 1'b0;
        end
    end

    assign bus.rd_cell = rd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.gen     = gen_q;
    assign bus.pop     = pop_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: five instances (default, dead border,
// 8x8 toroidal, 8x8 dead border, Seeds rule); one is addressed at a time.
module tb_life_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_data = 1'b0;
    logic [4:0] wr_x = '0;
    logic [4:0] wr_y = '0;
    logic [4:0] rd_x = '0;
    logic [4:0] rd_y = '0;
    int         dut_id = 0;
    int         errors = 0;
    int         checks = 0;

    logic        rd_s;
    logic        busy_s;
    logic        done_s;
    logic [15:0] gen_s;
    logic [10:0] pop_s;

    always #5 clk = ~clk;

    life_engine_if #(.XW(5), .YW(5), .POPW(11)) if_a ();
    life_engine_if #(.XW(5), .YW(5), .POPW(11)) if_b ();
    life_engine_if #(.XW(3), .YW(3), .POPW(7))  if_c ();
    life_engine_if #(.XW(3), .YW(3), .POPW(7))  if_d ();
    life_engine_if #(.XW(5), .YW(5), .POPW(11)) if_e ();

    assign if_a.start = start & (dut_id == 0);
    assign if_a.clr   = clr   & (dut_id == 0);
    assign if_a.wr_en = wr_en & (dut_id == 0);
    assign if_a.wr_x  = wr_x;
    assign if_a.wr_y  = wr_y;
    assign if_a.wr_data = wr_data;
    assign if_a.rd_x  = rd_x;
    assign if_a.rd_y  = rd_y;

    assign if_b.start = start & (dut_id == 1);
    assign if_b.clr   = clr   & (dut_id == 1);
    assign if_b.wr_en = wr_en & (dut_id == 1);
    assign if_b.wr_x  = wr_x;
    assign if_b.wr_y  = wr_y;
    assign if_b.wr_data = wr_data;
    assign if_b.rd_x  = rd_x;
    assign if_b.rd_y  = rd_y;

    assign if_c.start = start & (dut_id == 2);
    assign if_c.clr   = clr   & (dut_id == 2);
    assign if_c.wr_en = wr_en & (dut_id == 2);
    assign if_c.wr_x  = wr_x[2:0];
    assign if_c.wr_y  = wr_y[2:0];
    assign if_c.wr_data = wr_data;
    assign if_c.rd_x  = rd_x[2:0];
    assign if_c.rd_y  = rd_y[2:0];

    assign if_d.start = start & (dut_id == 3);
    assign if_d.clr   = clr   & (dut_id == 3);
    assign if_d.wr_en = wr_en & (dut_id == 3);
    assign if_d.wr_x  = wr_x[2:0];
    assign if_d.wr_y  = wr_y[2:0];
    assign if_d.wr_data = wr_data;
    assign if_d.rd_x  = rd_x[2:0];
    assign if_d.rd_y  = rd_y[2:0];

    assign if_e.start = start & (dut_id == 4);
    assign if_e.clr   = clr   & (dut_id == 4);
    assign if_e.wr_en = wr_en & (dut_id == 4);
    assign if_e.wr_x  = wr_x;
    assign if_e.wr_y  = wr_y;
    assign if_e.wr_data = wr_data;
    assign if_e.rd_x  = rd_x;
    assign if_e.rd_y  = rd_y;

    life_engine u_a (.clk(clk), .rst(rst), .bus(if_a));
    life_engine #(.WRAP(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    life_engine #(.W(8), .H(8), .WRAP(1), .XW(3), .YW(3), .POPW(7)) u_c (.clk(clk), .rst(rst), .bus(if_c));
    life_engine #(.W(8), .H(8), .WRAP(0), .XW(3), .YW(3), .POPW(7)) u_d (.clk(clk), .rst(rst), .bus(if_d));
    life_engine #(.RULE_B(9'b000000100), .RULE_S(9'b000000000)) u_e (.clk(clk), .rst(rst), .bus(if_e));

    // Route the addressed instance's outputs to common observation signals.
    always_comb begin
        rd_s = 1'b0; busy_s = 1'b0; done_s = 1'b0; gen_s = '0; pop_s = '0;
        case (dut_id)
            0: begin rd_s = if_a.rd_cell; busy_s = if_a.busy; done_s = if_a.done; gen_s = if_a.gen; pop_s = if_a.pop; end
            1: begin rd_s = if_b.rd_cell; busy_s = if_b.busy; done_s = if_b.done; gen_s = if_b.gen; pop_s = if_b.pop; end
            2: begin rd_s = if_c.rd_cell; busy_s = if_c.busy; done_s = if_c.done; gen_s = if_c.gen; pop_s = {4'b0, if_c.pop}; end
            3: begin rd_s = if_d.rd_cell; busy_s = if_d.busy; done_s = if_d.done; gen_s = if_d.gen; pop_s = {4'b0, if_d.pop}; end
            4: begin rd_s = if_e.rd_cell; busy_s = if_e.busy; done_s = if_e.done; gen_s = if_e.gen; pop_s = if_e.pop; end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int x, input int y, input logic d);
        wr_en = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int x, input int y, input logic e);
        rd_x = 5'(x); rd_y = 5'(y);
        tick();
        chk(tag, 32'(rd_s), 32'(e));
    endtask

    // Called in the first cycle after the start edge; latency counts that cycle as 1.
    task automatic wait_done(input int exp_lat);
        int lat;
        lat = 1;
        while (!done_s && lat < 60) begin
            tick();
            lat++;
        end
        chk("step_latency", lat, exp_lat);
    endtask

    task automatic step(input int exp_lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(exp_lat);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int ndone;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        dut_id = 0;
        chk("rst_busy", 32'(busy_s), 0);
        chk("rst_done", 32'(done_s), 0);
        chk("rst_gen", 32'(gen_s), 0);
        chk("rst_pop", 32'(pop_s), 0);
        rd_chk("rst_rd", 0, 0, 1'b0);

        // Blinker on the default instance; write->read latency
        wr(10, 5, 1'b1);
        rd_chk("wr_rd_latency", 10, 5, 1'b1);
        wr(11, 5, 1'b1);
        wr(12, 5, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_on", 32'(busy_s), 1);
        wait_done(25);
        chk("busy_off_at_done", 32'(busy_s), 0);
        chk("blink1_gen", 32'(gen_s), 1);
        chk("blink1_pop", 32'(pop_s), 3);
        tick();
        chk("done_one_cycle", 32'(done_s), 0);
        rd_chk("blink1_11_4", 11, 4, 1'b1);
        rd_chk("blink1_11_5", 11, 5, 1'b1);
        rd_chk("blink1_11_6", 11, 6, 1'b1);
        rd_chk("blink1_10_5", 10, 5, 1'b0);
        rd_chk("blink1_12_5", 12, 5, 1'b0);
        step(25);
        chk("blink2_gen", 32'(gen_s), 2);
        chk("blink2_pop", 32'(pop_s), 3);
        rd_chk("blink2_10_5", 10, 5, 1'b1);
        rd_chk("blink2_12_5", 12, 5, 1'b1);
        rd_chk("blink2_11_4", 11, 4, 1'b0);

        // start and wr_en during CALC are dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; wr_en = 1'b1; wr_x = 5'd11; wr_y = 5'd10; wr_data = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            if (done_s) ndone++;
            tick();
        end
        chk("calc_start_ignored", ndone, 1);
        chk("calc_gen", 32'(gen_s), 3);
        chk("calc_pop", 32'(pop_s), 3);
        rd_chk("calc_wr_ignored", 11, 10, 1'b0);
        rd_chk("pre_clr", 11, 5, 1'b1);

        // clr + start in the same cycle: grid cleared, no step
        clr = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0;
        chk("clr_no_busy", 32'(busy_s), 0);
        tick();
        chk("clr_rd_next", 32'(rd_s), 0);
        chk("clr_pop", 32'(pop_s), 0);
        chk("clr_gen_kept", 32'(gen_s), 3);

        // Out-of-range write ignored, out-of-range read returns 0
        wr(5, 24, 1'b1);
        rd_chk("oor_read", 5, 24, 1'b0);

        // Write in the same cycle as start is seen by that step
        wr(20, 10, 1'b1);
        wr(21, 10, 1'b1);
        wr_en = 1'b1; wr_x = 5'd22; wr_y = 5'd10; wr_data = 1'b1; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        wait_done(25);
        chk("wrstart_pop", 32'(pop_s), 3);
        chk("wrstart_gen", 32'(gen_s), 4);
        rd_chk("wrstart_21_9", 21, 9, 1'b1);
        rd_chk("wrstart_21_11", 21, 11, 1'b1);
        rd_chk("wrstart_20_10", 20, 10, 1'b0);

        // Block across all four corners, toroidal
        do_clr();
        wr(31, 23, 1'b1);
        wr(0, 23, 1'b1);
        wr(31, 0, 1'b1);
        wr(0, 0, 1'b1);
        step(25);
        step(25);
        chk("wrapblk_pop", 32'(pop_s), 4);
        chk("wrapblk_gen", 32'(gen_s), 6);
        rd_chk("wrapblk_31_23", 31, 23, 1'b1);
        rd_chk("wrapblk_0_0", 0, 0, 1'b1);
        rd_chk("wrapblk_30_23", 30, 23, 1'b0);
        rd_chk("wrapblk_1_0", 1, 0, 1'b0);

        // Block at origin, dead border
        dut_id = 1;
        wr(0, 0, 1'b1);
        wr(1, 0, 1'b1);
        wr(0, 1, 1'b1);
        wr(1, 1, 1'b1);
        for (int s = 0; s < 4; s++) step(25);
        chk("blk_pop", 32'(pop_s), 4);
        chk("blk_gen", 32'(gen_s), 4);
        rd_chk("blk_1_1", 1, 1, 1'b1);
        rd_chk("blk_2_0", 2, 0, 1'b0);

        // Glider on 8x8 torus returns home after 32 generations
        dut_id = 2;
        wr(1, 0, 1'b1);
        wr(2, 1, 1'b1);
        wr(0, 2, 1'b1);
        wr(1, 2, 1'b1);
        wr(2, 2, 1'b1);
        for (int s = 0; s < 32; s++) begin
            step(9);
            chk("glider_pop", 32'(pop_s), 5);
        end
        chk("glider_gen", 32'(gen_s), 32);
        rd_chk("glider_1_0", 1, 0, 1'b1);
        rd_chk("glider_2_1", 2, 1, 1'b1);
        rd_chk("glider_0_2", 0, 2, 1'b1);
        rd_chk("glider_2_2", 2, 2, 1'b1);
        rd_chk("glider_0_0", 0, 0, 1'b0);

        // Glider in the corner of a dead-border 8x8 decays to a block
        dut_id = 3;
        wr(6, 5, 1'b1);
        wr(7, 6, 1'b1);
        wr(5, 7, 1'b1);
        wr(6, 7, 1'b1);
        wr(7, 7, 1'b1);
        step(9);
        chk("corner_pop1", 32'(pop_s), 4);
        step(9);
        chk("corner_pop2", 32'(pop_s), 3);
        step(9);
        chk("corner_pop3", 32'(pop_s), 4);
        step(9);
        chk("corner_pop4", 32'(pop_s), 4);
        rd_chk("corner_6_6", 6, 6, 1'b1);
        rd_chk("corner_7_7", 7, 7, 1'b1);
        rd_chk("corner_5_6", 5, 6, 1'b0);

        // Seeds rule (B2/S): horizontal domino -> dominoes above and below
        dut_id = 4;
        wr(3, 3, 1'b1);
        wr(4, 3, 1'b1);
        step(25);
        chk("seeds_pop", 32'(pop_s), 4);
        rd_chk("seeds_3_3", 3, 3, 1'b0);
        rd_chk("seeds_4_3", 4, 3, 1'b0);
        rd_chk("seeds_3_2", 3, 2, 1'b1);
        rd_chk("seeds_4_4", 4, 4, 1'b1);

        // Reset in the middle of a step
        dut_id = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy_s), 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_s) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_gen", 32'(gen_s), 0);
        chk("abort_pop", 32'(pop_s), 0);
        rd_chk("abort_31_23", 31, 23, 1'b0);
        rd_chk("abort_0_0", 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
